// File: rtl/mult_unit.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one partial product per clock.
// Fixed latency: done is high in the cycle after the 16th iteration edge.
//
// state  | meaning
// S_IDLE | waiting for i_init; o_result holds the last product
// S_CALC | 16 shift-and-add iterations, o_result shows partial sums
// S_DONE | o_done high for one cycle, o_result final
module mult_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_init,
    input  logic [15:0] i_op_a,
    input  logic [15:0] i_op_b,
    output logic [31:0] o_result,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a_sh;
    logic [15:0] r_b_sh;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_init) w_next = S_CALC;
            S_CALC: if (r_cnt == 5'd15) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operands are captured only on the accepting edge; later bus changes are ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sh <= 32'd0;
            r_b_sh <= 16'd0;
            r_acc  <= 32'd0;
            r_cnt  <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_init) begin
                        r_a_sh <= {16'd0, i_op_a};
                        r_b_sh <= i_op_b;
                        r_acc  <= 32'd0;
                        r_cnt  <= 5'd0;
                    end
                end
                S_CALC: begin
                    if (r_b_sh[0]) begin
                        r_acc <= r_acc + r_a_sh;
                    end
                    r_a_sh <= r_a_sh << 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_result = r_acc;
    assign o_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_mult_unit.sv
// Directed testbench for mult_unit: products, latency, init handling and async reset.
// Latency is counted in edges after the init-sample edge E0; done is seen after E16.
module tb_mult_unit;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] result;
    logic        done;

    int checks   = 0;
    int failures = 0;

    mult_unit dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_init   (init),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .o_result (result),
        .o_done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Waits for done after the init-sample edge; returns edges counted since E0.
    task automatic wait_done(input int hold, output int n);
        n = 0;
        if (hold <= 1) init = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n >= hold - 1) init = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input logic [31:0] exp);
        int n;
        int extra;
        @(negedge clk);
        op_a = a;
        op_b = b;
        init = 1'b1;
        @(posedge clk); #1;
        wait_done(hold, n);
        chk({tag, "_latency"}, 32'(n), 32'd16);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_result"}, result, exp);
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk({tag, "_no_restart"}, 32'(extra), 32'd0);
        chk({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        int n;
        int extra;
        rst_n = 1'b0;
        init  = 1'b0;
        op_a  = 16'd0;
        op_b  = 16'd0;
        #12;
        chk("reset_result", result, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("a55_b33", 16'h0055, 16'h0033, 2, 32'h0000_10EF);
        run_op("ffff_sq", 16'hFFFF, 16'hFFFF, 1, 32'hFFFE_0001);
        run_op("x1234_5678", 16'h1234, 16'h5678, 1, 32'h0626_0060);
        run_op("zero_a", 16'h0000, 16'hBEEF, 1, 32'h0000_0000);
        run_op("one_msb", 16'h0001, 16'h8000, 1, 32'h0000_8000);
        run_op("msb_sq", 16'h8000, 16'h8000, 1, 32'h4000_0000);

        // Operand changes and a second init during CALC must be ignored.
        @(negedge clk);
        op_a = 16'h1234;
        op_b = 16'h5678;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        init = 1'b0;
        n = 7;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("calc_ignore_latency", 32'(n), 32'd16);
        chk("calc_ignore_result", result, 32'h0626_0060);
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("calc_ignore_single_done", 32'(extra), 32'd0);

        // Async reset after iteration 8 discards the partial product.
        @(negedge clk);
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("partial_iter8", result, 32'h00FE_FF01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_result", result, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("abort_no_done", 32'(extra), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", 16'h0055, 16'h0033, 1, 32'h0000_10EF);

        // Continuous init: back-to-back operations every 18 clocks.
        @(negedge clk);
        op_a = 16'h0003;
        op_b = 16'h0007;
        init = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cont_first_latency", 32'(n), 32'd16);
        chk("cont_first_result", result, 32'h0000_0015);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            @(posedge clk); #1;
            n++;
            while (!done && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk("cont_spacing", 32'(n), 32'd18);
            chk("cont_result", result, 32'h0000_0015);
        end
        init = 1'b0;
        extra = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("cont_stop", 32'(extra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
